// File: rtl/bob_retire_ctl_pkg.sv
// Shared definitions for the bob retire controller.
//   - FSM state encoding
//   - bob entry field layout: {pred_taken, pred_target, fallthru_ip}
//   - default flush length and flush counter width
package bob_retire_ctl_pkg;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  localparam int unsigned FLUSH_CYC_DEF = 3;
  // Holds FLUSH_CYC values in the range 1..15.
  localparam int unsigned FCNT_W        = 4;

  // Entry layout offsets, expressed in terms of the address width.
  localparam int unsigned FT_LSB = 0;
  function automatic int unsigned tgt_lsb(input int unsigned ipw);
    return ipw;
  endfunction
  function automatic int unsigned tkn_bit(input int unsigned ipw);
    return 2 * ipw;
  endfunction
  function automatic int unsigned entry_w(input int unsigned ipw);
    return 2 * ipw + 1;
  endfunction

endpackage

// File: rtl/adder_inc.sv
// Incrementer: y = a + 1. Wraps from all-ones to zero.
//   a  in  W  operand
//   y  out W  a + 1
module adder_inc #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = a + W'(1);
endmodule

// File: rtl/bob_ret_cmp.sv
// Combinational mispredict compare and redirect address select for one
// retiring branch.
//   entry       in  2*IP_WIDTH+1  bob entry {pred_taken, pred_target, fallthru_ip}
//   act_taken   in  1             actual direction
//   act_target  in  IP_WIDTH      actual taken target
//   mis         out 1             prediction was wrong
//   redir_ip    out IP_WIDTH      where the front end must restart
module bob_ret_cmp
  import bob_retire_ctl_pkg::*;
#(
  parameter int IP_WIDTH = 64
) (
  input  logic [2*IP_WIDTH:0]  entry,
  input  logic                 act_taken,
  input  logic [IP_WIDTH-1:0]  act_target,
  output logic                 mis,
  output logic [IP_WIDTH-1:0]  redir_ip
);
  logic                pred_taken;
  logic [IP_WIDTH-1:0] pred_target;
  logic [IP_WIDTH-1:0] fallthru_ip;

  assign pred_taken  = entry[tkn_bit(IP_WIDTH)];
  assign pred_target = entry[tgt_lsb(IP_WIDTH) +: IP_WIDTH];
  assign fallthru_ip = entry[FT_LSB +: IP_WIDTH];

  // The target only matters when the branch was actually taken.
  assign mis      = (act_taken != pred_taken) |
                    (act_taken & (act_target != pred_target));
  assign redir_ip = act_taken ? act_target : fallthru_ip;
endmodule

// File: rtl/bob_retire_ctl.sv
// Retire-side controller for the branch order buffer.
// Pops the bob head when the ROB retires a branch, checks the stored
// prediction, and on a mispredict issues a registered redirect followed by a
// fixed-length flush (except/rob_stall) back into the bob allocator.
//   clk, rst        clock, async active-low reset
//   hasRetire       bob non-empty
//   retire_addr     allocator head pointer (already advanced by doRetire)
//   ram_read_data   head entry from the bob RAM
//   rob_br_*        branch retiring from the ROB
//   ram_read_*      bob RAM read port
//   doRetire        pop the bob head
//   except          flush the allocator
//   rob_stall       hold ROB branch retirement
//   redirect_*      one-cycle front-end redirect
//   err_underflow   sticky retire-while-empty error
//   retired_cnt     branches retired
//   mispred_cnt     mispredicts
module bob_retire_ctl
  import bob_retire_ctl_pkg::*;
#(
  parameter int IP_WIDTH   = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 2*IP_WIDTH+1,
  parameter int FLUSH_CYC  = FLUSH_CYC_DEF,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hasRetire,
  input  logic [ADDR_WIDTH-1:0] retire_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data,
  input  logic                  rob_br_valid,
  input  logic                  rob_br_taken,
  input  logic [IP_WIDTH-1:0]   rob_br_target,
  output logic                  ram_read_clkEn,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic                  doRetire,
  output logic                  except,
  output logic                  rob_stall,
  output logic                  redirect_valid,
  output logic [IP_WIDTH-1:0]   redirect_ip,
  output logic                  err_underflow,
  output logic [CNT_WIDTH-1:0]  retired_cnt,
  output logic [CNT_WIDTH-1:0]  mispred_cnt
);
  state_e               state;
  logic [FCNT_W-1:0]    fcnt;
  logic                 mis;
  logic [IP_WIDTH-1:0]  rip;
  logic [CNT_WIDTH-1:0] ret_nxt;
  logic [CNT_WIDTH-1:0] mis_nxt;

  // The RAM registers the address itself, so the head entry simply follows
  // the allocator pointer one cycle later.
  assign ram_read_clkEn = 1'b1;
  assign ram_read_addr  = retire_addr;

  // Gated by rst so no pop escapes while the block is held in reset.
  assign doRetire = rst & (state == RUN) & rob_br_valid & hasRetire;

  bob_ret_cmp #(.IP_WIDTH(IP_WIDTH)) u_cmp (
    .entry      (ram_read_data),
    .act_taken  (rob_br_taken),
    .act_target (rob_br_target),
    .mis        (mis),
    .redir_ip   (rip)
  );

  adder_inc #(.W(CNT_WIDTH)) u_ret_inc (.a(retired_cnt), .y(ret_nxt));
  adder_inc #(.W(CNT_WIDTH)) u_mis_inc (.a(mispred_cnt), .y(mis_nxt));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= RUN;
      fcnt           <= '0;
      except         <= 1'b0;
      rob_stall      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_ip    <= '0;
      err_underflow  <= 1'b0;
      retired_cnt    <= '0;
      mispred_cnt    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      case (state)
        RUN: begin
          if (doRetire) begin
            retired_cnt <= ret_nxt;
            if (mis) begin
              redirect_valid <= 1'b1;
              redirect_ip    <= rip;
              mispred_cnt    <= mis_nxt;
              fcnt           <= FCNT_W'(FLUSH_CYC);
              except         <= 1'b1;
              rob_stall      <= 1'b1;
              state          <= FLUSH;
            end
          end
          if (rob_br_valid && !hasRetire) err_underflow <= 1'b1;
        end
        FLUSH: begin
          // fcnt==1 marks the last flush cycle.
          if (fcnt == FCNT_W'(1)) begin
            state     <= RUN;
            except    <= 1'b0;
            rob_stall <= 1'b0;
            fcnt      <= '0;
          end else begin
            fcnt <= fcnt - FCNT_W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_bob_retire_ctl.sv
module tb_bob_retire_ctl;
  localparam int IPW = 64;
  localparam int AW  = 6;
  localparam int DW  = 2*IPW+1;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          hasRetire;
  logic [AW-1:0] retire_addr;
  logic [DW-1:0] ram_read_data;
  logic          rob_br_valid;
  logic          rob_br_taken;
  logic [IPW-1:0] rob_br_target;
  logic          ram_read_clkEn;
  logic [AW-1:0] ram_read_addr;
  logic          doRetire;
  logic          except;
  logic          rob_stall;
  logic          redirect_valid;
  logic [IPW-1:0] redirect_ip;
  logic          err_underflow;
  logic [CW-1:0] retired_cnt;
  logic [CW-1:0] mispred_cnt;

  always #5 clk = ~clk;

  bob_retire_ctl #(.IP_WIDTH(IPW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                   .FLUSH_CYC(3), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .hasRetire(hasRetire), .retire_addr(retire_addr),
    .ram_read_data(ram_read_data), .rob_br_valid(rob_br_valid),
    .rob_br_taken(rob_br_taken), .rob_br_target(rob_br_target),
    .ram_read_clkEn(ram_read_clkEn), .ram_read_addr(ram_read_addr),
    .doRetire(doRetire), .except(except), .rob_stall(rob_stall),
    .redirect_valid(redirect_valid), .redirect_ip(redirect_ip),
    .err_underflow(err_underflow), .retired_cnt(retired_cnt),
    .mispred_cnt(mispred_cnt)
  );

  typedef struct { logic [AW-1:0] addr; } pop_exp_t;
  typedef struct { logic [IPW-1:0] ip; } redir_exp_t;

  pop_exp_t   pop_q[$];
  redir_exp_t redir_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every pop or redirect the DUT presents must match the next
  // expected item issued by the stimulus.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (doRetire) begin
        if (pop_q.size() == 0) chk("unexpected_pop", 1, 0);
        else begin
          pop_exp_t p;
          p = pop_q.pop_front();
          chk("pop_addr", 64'(ram_read_addr), 64'(p.addr));
        end
      end
      if (redirect_valid) begin
        if (redir_q.size() == 0) chk("unexpected_redirect", 1, 0);
        else begin
          redir_exp_t r;
          r = redir_q.pop_front();
          chk("redirect_ip", redirect_ip, r.ip);
          chk("except_at_redirect", 64'(except), 1);
          chk("stall_at_redirect", 64'(rob_stall), 1);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] ent(input logic t, input logic [63:0] tgt, input logic [63:0] ft);
    return {t, tgt, ft};
  endfunction

  // Drive one retiring branch for the current cycle and record the expectation.
  task automatic issue(input logic [DW-1:0] e, input logic tk, input logic [63:0] tgt,
                       input logic exp_mis, input logic [63:0] exp_ip);
    pop_exp_t   p;
    redir_exp_t r;
    ram_read_data = e;
    rob_br_valid  = 1'b1;
    rob_br_taken  = tk;
    rob_br_target = tgt;
    hasRetire     = 1'b1;
    p.addr = retire_addr;
    pop_q.push_back(p);
    if (exp_mis) begin
      r.ip = exp_ip;
      redir_q.push_back(r);
    end
  endtask

  logic [AW-1:0] head;

  initial begin
    rst = 1'b0; hasRetire = 1'b1; retire_addr = 6'd5; ram_read_data = '0;
    rob_br_valid = 1'b1; rob_br_taken = 1'b1; rob_br_target = '0;

    // Reset with retire stimulus active.
    @(negedge clk);
    chk("rst_doRetire", 64'(doRetire), 0);
    chk("rst_except", 64'(except), 0);
    chk("rst_stall", 64'(rob_stall), 0);
    chk("rst_redir", 64'(redirect_valid), 0);
    chk("rst_err", 64'(err_underflow), 0);
    chk("rst_retcnt", 64'(retired_cnt), 0);
    chk("rst_miscnt", 64'(mispred_cnt), 0);
    chk("rst_clkEn", 64'(ram_read_clkEn), 1);
    chk("rst_addr", 64'(ram_read_addr), 5);
    rob_br_valid = 1'b0;
    rst = 1'b1;
    cyc();

    // Correct prediction.
    issue(ent(1'b1, 64'h1000, 64'h2004), 1'b1, 64'h1000, 1'b0, 0);
    @(negedge clk);
    chk("ok_doRetire", 64'(doRetire), 1);
    cyc();
    rob_br_valid = 1'b0; retire_addr = 6'd6;
    @(negedge clk);
    chk("ok_retcnt", 64'(retired_cnt), 1);
    chk("ok_no_redir", 64'(redirect_valid), 0);
    chk("ok_no_except", 64'(except), 0);

    // Direction mispredict: predicted not-taken, actually taken.
    cyc();
    issue(ent(1'b0, 64'h1000, 64'h2004), 1'b1, 64'h1000, 1'b1, 64'h1000);
    cyc();                              // N+1
    rob_br_valid = 1'b0; retire_addr = 6'd7;
    @(negedge clk);
    chk("dir_except_n1", 64'(except), 1);
    chk("dir_redir_n1", 64'(redirect_valid), 1);
    chk("dir_miscnt", 64'(mispred_cnt), 1);
    cyc();                              // N+2
    @(negedge clk);
    chk("dir_except_n2", 64'(except), 1);
    chk("dir_redir_n2", 64'(redirect_valid), 0);
    cyc();                              // N+3
    @(negedge clk);
    chk("dir_except_n3", 64'(except), 1);
    chk("dir_stall_n3", 64'(rob_stall), 1);
    cyc();                              // N+4
    @(negedge clk);
    chk("dir_except_n4", 64'(except), 0);
    chk("dir_stall_n4", 64'(rob_stall), 0);
    chk("dir_retcnt", 64'(retired_cnt), 2);

    // Target mispredict with rob_br_valid held through the flush.
    cyc();
    issue(ent(1'b1, 64'h1000, 64'h2004), 1'b1, 64'h1800, 1'b1, 64'h1800);
    retire_addr = 6'd7;
    for (int i = 1; i <= 3; i++) begin
      cyc();                            // N+i, valid still high
      if (i == 1) retire_addr = 6'd8;
      @(negedge clk);
      chk($sformatf("tgt_noPop_n%0d", i), 64'(doRetire), 0);
      chk($sformatf("tgt_stall_n%0d", i), 64'(rob_stall), 1);
    end
    cyc();                              // N+4: RUN again, correct branch pops
    issue(ent(1'b1, 64'h1000, 64'h2004), 1'b1, 64'h1000, 1'b0, 0);
    @(negedge clk);
    chk("tgt_resume_pop", 64'(doRetire), 1);
    chk("tgt_err_none", 64'(err_underflow), 0);
    cyc();
    retire_addr = 6'd9;

    // Predicted taken, actually not taken: redirect to fallthrough.
    issue(ent(1'b1, 64'h3000, 64'h2468), 1'b0, 64'h0, 1'b1, 64'h2468);
    cyc();
    rob_br_valid = 1'b0; retire_addr = 6'd10;
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("nt_retcnt", 64'(retired_cnt), 5);
    chk("nt_miscnt", 64'(mispred_cnt), 3);
    chk("nt_except_done", 64'(except), 0);

    // Underflow.
    cyc();
    rob_br_valid = 1'b1; hasRetire = 1'b0;
    @(negedge clk);
    chk("uf_doRetire", 64'(doRetire), 0);
    cyc();
    rob_br_valid = 1'b0; hasRetire = 1'b1;
    @(negedge clk);
    chk("uf_err", 64'(err_underflow), 1);
    chk("uf_retcnt", 64'(retired_cnt), 5);
    cyc(); cyc();
    @(negedge clk);
    chk("uf_err_sticky", 64'(err_underflow), 1);

    // Streaming: 62 back-to-back correct retires, head wraps 61->62->0.
    cyc();
    head = 6'd40;
    for (int i = 0; i < 62; i++) begin
      retire_addr = head;
      issue(ent(1'b0, 64'h0, 64'h4000 + 64'(i)), 1'b0, 64'h0, 1'b0, 0);
      @(negedge clk);
      chk("str_addr", 64'(ram_read_addr), 64'(head));
      cyc();
      head = (head == 6'd62) ? 6'd0 : head + 6'd1;
    end
    rob_br_valid = 1'b0; retire_addr = head;
    @(negedge clk);
    chk("str_retcnt", 64'(retired_cnt), 67);
    chk("str_miscnt", 64'(mispred_cnt), 3);

    // Reset asserted in the middle of a flush.
    cyc();
    issue(ent(1'b0, 64'h1000, 64'h2004), 1'b1, 64'h5000, 1'b0, 0);
    cyc();                              // N+1: flush in progress
    rob_br_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_except", 64'(except), 0);
    chk("mid_rst_redir", 64'(redirect_valid), 0);
    chk("mid_rst_retcnt", 64'(retired_cnt), 0);
    cyc();
    rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("post_rst_except", 64'(except), 0);
    chk("post_rst_err", 64'(err_underflow), 0);
    chk("post_rst_miscnt", 64'(mispred_cnt), 0);

    chk("pop_q_drained", 64'(pop_q.size()), 0);
    chk("redir_q_drained", 64'(redir_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
